// File: rtl/axi4ar_pkg.sv
// ---------------------------------------------------------------------------
// axi4ar_pkg
// Shared definitions for the AXI4 read-address burst generator:
//   AXI_BURST_INCR   - AR burst type INCR
//   AXI_SIZE_4B      - AR size for 32-bit beats
//   AR_CACHE_DEFAULT - AR cache attribute (normal, non-cacheable, bufferable)
//   CREDIT_W         - width of the outstanding-burst credit counter
//   ar_req_t         - one AR request (address, length, id)
//   state_t          - generator FSM states
// ---------------------------------------------------------------------------
package axi4ar_pkg;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B      = 3'd2;
  localparam logic [3:0] AR_CACHE_DEFAULT = 4'b0011;

  // Enough for up to 15 outstanding bursts.
  localparam int CREDIT_W = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  id;
  } ar_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/axi4ar_split_calc.sv
// ---------------------------------------------------------------------------
// axi4ar_split_calc
// Combinational burst sizing: the number of 32-bit beats of the next burst is
// the smallest of the beats still to fetch, MAX_BEATS, and the beats left
// before the next 4 KB boundary.
// Ports:
//   word_lo   in  10       address bits [11:2] (word index inside the 4 KB page)
//   remaining in  BEATS_W  beats still to fetch (must be non-zero when used)
//   beats     out 9        beats of the next burst (1..256)
//   len       out 8        AXI arlen = beats-1
// ---------------------------------------------------------------------------
module axi4ar_split_calc #(
  parameter int MAX_BEATS = 16,
  parameter int BEATS_W   = 12
) (
  input  logic [9:0]         word_lo,
  input  logic [BEATS_W-1:0] remaining,
  output logic [8:0]         beats,
  output logic [7:0]         len
);

  logic [10:0] to4k;
  logic [8:0]  cap;

  always_comb begin
    // Words left in the current 4 KB page, 1..1024.
    to4k  = 11'd1024 - {1'b0, word_lo};
    // The page limit and MAX_BEATS together are at most 256, so fit 9 bits.
    cap   = (to4k < 11'(MAX_BEATS)) ? 9'(to4k) : 9'(MAX_BEATS);
    beats = (32'(remaining) < 32'(cap)) ? 9'(remaining) : cap;
    len   = 8'(beats - 9'd1);
  end

endmodule

// File: rtl/axi4ar_burst_gen.sv
// ---------------------------------------------------------------------------
// axi4ar_burst_gen
// Splits a word-read request (start address, beat count, id) into legal AXI4
// INCR bursts on the AR channel, bounded by MAX_BEATS and by 4 KB pages, and
// throttled by a credit counter of issued-but-uncompleted bursts.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr/req_beats/req_id  request payload (word-aligned byte address)
//   busy                       request in progress or bursts outstanding
//   burst_done                 one pulse per completed burst from the R side
//   ar*                        AXI4 AR channel
//   perf_bursts                AR handshake counter (0 unless enabled)
// Build option: define AXI4AR_PERF_CNT_EN to build the perf_bursts counter.
// ---------------------------------------------------------------------------
module axi4ar_burst_gen
  import axi4ar_pkg::*;
#(
  parameter int MAX_BEATS       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEATS_W         = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [BEATS_W-1:0] req_beats,
  input  logic [1:0]         req_id,
  output logic               busy,
  input  logic               burst_done,
  output logic [1:0]         arid,
  output logic [31:0]        araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arlock,
  output logic [3:0]         arcache,
  output logic [2:0]         arprot,
  output logic [3:0]         arqos,
  output logic [3:0]         arregion,
  output logic               arvalid,
  input  logic               arready,
  output logic [31:0]        perf_bursts
);

  state_t               state_reg, state_next;
  logic [31:0]          addr_reg, addr_next;
  logic [BEATS_W-1:0]   rem_reg, rem_next;
  logic [1:0]           id_reg, id_next;
  logic [8:0]           n_reg, n_next;
  ar_req_t              ar_reg, ar_next;
  logic                 arvalid_reg, arvalid_next;
  logic [CREDIT_W-1:0]  credit_reg, credit_next;

  logic [8:0]           calc_beats;
  logic [7:0]           calc_len;
  logic                 ar_hs;
  logic                 done_ok;

  axi4ar_split_calc #(
    .MAX_BEATS (MAX_BEATS),
    .BEATS_W   (BEATS_W)
  ) u_split_calc (
    .word_lo   (addr_reg[11:2]),
    .remaining (rem_reg),
    .beats     (calc_beats),
    .len       (calc_len)
  );

  assign ar_hs   = arvalid_reg && arready;
  // A completion with nothing outstanding is a protocol error and is dropped.
  assign done_ok = burst_done && (credit_reg != '0);

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    rem_next     = rem_reg;
    id_next      = id_reg;
    n_next       = n_reg;
    ar_next      = ar_reg;
    arvalid_next = arvalid_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          // Low address bits are forced to zero: misaligned input is ignored.
          addr_next = {req_addr[31:2], 2'b00};
          rem_next  = req_beats;
          id_next   = req_id;
          if (req_beats != '0) begin
            state_next = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        // AR fields are reloaded every stall cycle; the values do not change.
        ar_next = '{addr: addr_reg, len: calc_len, id: id_reg};
        n_next  = calc_beats;
        if (credit_reg < CREDIT_W'(MAX_OUTSTANDING)) begin
          arvalid_next = 1'b1;
          state_next   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (arready) begin
          arvalid_next = 1'b0;
          addr_next    = addr_reg + (32'(n_reg) << 2);
          rem_next     = rem_reg - BEATS_W'(n_reg);
          state_next   = (rem_reg == BEATS_W'(n_reg)) ? ST_IDLE : ST_CALC;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        arvalid_next = 1'b0;
      end
    endcase

    credit_next = credit_reg;
    if (ar_hs && !done_ok) begin
      credit_next = credit_reg + 1'b1;
    end else if (!ar_hs && done_ok) begin
      credit_next = credit_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      rem_reg     <= '0;
      id_reg      <= '0;
      n_reg       <= '0;
      ar_reg      <= '0;
      arvalid_reg <= 1'b0;
      credit_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      rem_reg     <= rem_next;
      id_reg      <= id_next;
      n_reg       <= n_next;
      ar_reg      <= ar_next;
      arvalid_reg <= arvalid_next;
      credit_reg  <= credit_next;
    end
  end

  assign req_ready = (state_reg == ST_IDLE) && !rst;
  assign busy      = (state_reg != ST_IDLE) || (credit_reg != '0);

  assign arvalid   = arvalid_reg;
  assign araddr    = ar_reg.addr;
  assign arlen     = ar_reg.len;
  assign arid      = ar_reg.id;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign arlock    = 1'b0;
  assign arcache   = AR_CACHE_DEFAULT;
  assign arprot    = 3'b000;
  assign arqos     = 4'd0;
  assign arregion  = 4'd0;

`ifdef AXI4AR_PERF_CNT_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else if (ar_hs) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_bursts = perf_reg;
`else
  assign perf_bursts = '0;
`endif

  // Simulation-only protocol checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        assert (req_addr[1:0] == 2'b00);
      end
      if (burst_done) begin
        assert (credit_reg != '0);
      end
    end
  end

endmodule

// File: doc/axi4ar_burst_gen.md
Name: axi4ar_burst_gen

Overview:
- Read-address request generator directly upstream of the axi4ar channel. It converts a simple word-read request (start address, beat count, ID) into one or more legal AXI4 INCR bursts on the AR channel.
- Each burst is limited by MAX_BEATS and must not cross a 4 KB boundary.
- Throttles issue against an outstanding-burst credit counter that is returned by the R-channel consumer.
- Feeds the fetch/LSU read path into the AXI4 interconnect.

Parameters:
- MAX_BEATS, 16, max beats per burst (1..256); arlen = beats-1.
- MAX_OUTSTANDING, 4, max bursts issued but not yet completed (1..15).
- BEATS_W, 12, width of req_beats.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_addr  in  32  byte start address, word aligned.
- req_beats  in  BEATS_W  number of 32-bit beats.
- req_id  in  2  AXI ID for every burst of the request.
- busy  out  1  request in progress or bursts outstanding.
- burst_done  in  1  one pulse per completed burst (rvalid&rready&rlast).
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion  out  2/32/8/3/2/1/4/3/4/4  AXI4 AR fields.
- arvalid  out  1.
- arready  in  1.
- perf_bursts  out  32  see Optional Feature.

Behaviour:
- Reset values: arvalid=0, araddr=0, arlen=0, arid=0, req_ready=0 in the reset cycle then 1, busy=0, credit count=0. Constant fields: arsize=3'd2, arburst=2'b01 INCR, arlock=0, arcache=4'b0011, arprot=3'b000, arqos=0, arregion=0.
- FSM IDLE / CALC / ISSUE.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, remaining=req_beats and id, then go to CALC.
  - If req_beats==0, accept and stay IDLE; no AR is issued.
- CALC: 1 cycle.
  - to4k = (4096 - addr[11:0]) >> 2.
  - n = min(remaining, MAX_BEATS, to4k).
  - Register araddr=addr, arlen=n-1, arid=id.
  - If credit < MAX_OUTSTANDING, assert arvalid and go to ISSUE; else stall in CALC.
- ISSUE:
  - arvalid and all AR fields stay stable until arready.
  - On the handshake: credit += 1, addr += 4*n, remaining -= n.
  - If remaining==0, go to IDLE with arvalid=0; else go to CALC with arvalid=0.
- Latency: first arvalid appears 2 cycles after the req handshake. Each subsequent burst needs at least 2 cycles.
- Credit counter:
  - +1 on AR handshake, -1 on burst_done; both in the same cycle leaves it unchanged.
  - burst_done at credit 0 is ignored; a simulation assertion fires.
  - Saturation is impossible by construction.
- busy = (state != IDLE) | (credit != 0).
- Misaligned req_addr[1:0] is ignored (treated as 0); a simulation assertion fires.
- Address arithmetic is 32-bit modulo; wrap at 0xFFFFFFFC continues from 0.
- rst mid-burst: FSM goes to IDLE, arvalid is dropped, credit=0. This is legal only as a system-wide reset.

Optional Feature:
- Macro AXI4AR_PERF_CNT_EN.
- Defined: perf_bursts is a 32-bit counter, +1 per AR handshake, wraps, and resets to 0.
- Undefined: no counter is built and perf_bursts is tied to 0.

Decomposition:
- Shared package axi4ar_pkg:
  - AXI_BURST_INCR constant.
  - AXI_SIZE_4B constant.
  - AR_CACHE_DEFAULT constant.
  - ar_req_t struct (addr, len, id).
  - state enum.
- Sub-module axi4ar_split_calc: combinational n/arlen computation from addr, remaining and MAX_BEATS. It is unit-testable on its own.

Test Plan:
- req_addr=0x1000, beats=8, id=1, arready=1 -> one burst: araddr=0x1000, arlen=7, arid=1; credit=1 until burst_done.
- req_addr=0x0FF8, beats=4 -> two bursts: (0x0FF8, arlen=1) then (0x1000, arlen=1).
- req_addr=0x2000, beats=40, MAX_BEATS=16 -> bursts arlen=15, 15, 7 at 0x2000, 0x2040, 0x2080.
- MAX_OUTSTANDING=4, 6 single-beat requests, no burst_done -> exactly 4 AR handshakes, then the block stalls in CALC. One burst_done -> fifth AR issues.
- arready held low 10 cycles -> arvalid stays 1 and araddr/arlen stay stable. Simultaneous AR handshake and burst_done -> credit unchanged.
- rst asserted mid-ISSUE -> next cycle arvalid=0, busy=0. With AXI4AR_PERF_CNT_EN defined, perf_bursts=0 after reset and 3 after the third scenario.
